// File: rtl/dense_layer.sv
// Fully connected layer: streams one input vector through NUM_OUTPUTS parallel MACs,
// then rounds and saturates each accumulator back to the fixed-point word format.
module dense_layer #(
  parameter int NUM_INPUTS    = 784,
  parameter int NUM_OUTPUTS   = 10,
  parameter int FP_TOTAL_BITS = 16,
  parameter int FP_FRAC_BITS  = 8,
  localparam int CNT_BITS     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [NUM_OUTPUTS-1:0][FP_TOTAL_BITS-1:0]   bias,
  input  logic                                        in_valid,
  input  logic [FP_TOTAL_BITS-1:0]                    in_data,
  output logic                                        in_ready,
  output logic [CNT_BITS-1:0]                         w_addr,
  input  logic [NUM_OUTPUTS-1:0][FP_TOTAL_BITS-1:0]   w_data,
  output logic                                        busy,
  output logic                                        done,
  output logic [NUM_OUTPUTS-1:0][FP_TOTAL_BITS-1:0]   out_vector
);

  localparam int W        = FP_TOTAL_BITS;
  localparam int F        = FP_FRAC_BITS;
  localparam int ACC_BITS = 2*W + $clog2(NUM_INPUTS) + 1;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_INPUTS - 1);
  localparam logic signed [ACC_BITS-1:0] ROUND_HALF = ACC_BITS'(1) << (F - 1);
  localparam logic signed [ACC_BITS-1:0] MAX_POS = {{(ACC_BITS-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] MAX_NEG = {{(ACC_BITS-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                                  state_q;
  logic [CNT_BITS-1:0]                     cnt_q;
  logic signed [ACC_BITS-1:0]              acc_q [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0][W-1:0]           out_q;
  logic                                    done_q;

  logic signed [2*W-1:0]                   prod    [NUM_OUTPUTS];
  logic signed [ACC_BITS-1:0]              prod_ext[NUM_OUTPUTS];
  logic signed [ACC_BITS-1:0]              bias_ext[NUM_OUTPUTS];
  logic signed [ACC_BITS-1:0]              rnd     [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0][W-1:0]           out_d;

  assign in_ready   = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign w_addr     = cnt_q;
  assign done       = done_q;
  assign out_vector = out_q;

  // Per-neuron datapath: product, bias preload value, and the round/saturate result.
  always_comb begin
    out_d = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      prod[j]     = $signed(in_data) * $signed(w_data[j]);
      prod_ext[j] = {{(ACC_BITS-2*W){prod[j][2*W-1]}}, prod[j]};
      bias_ext[j] = {{(ACC_BITS-W-F){bias[j][W-1]}}, bias[j], {F{1'b0}}};
      rnd[j]      = (acc_q[j] + ROUND_HALF) >>> F;
      if (rnd[j] > MAX_POS)
        out_d[j] = MAX_POS[W-1:0];
      else if (rnd[j] < MAX_NEG)
        out_d[j] = MAX_NEG[W-1:0];
      else
        out_d[j] = rnd[j][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      for (int j = 0; j < NUM_OUTPUTS; j++) acc_q[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            for (int j = 0; j < NUM_OUTPUTS; j++) acc_q[j] <= bias_ext[j];
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) acc_q[j] <= acc_q[j] + prod_ext[j];
            // Counter parks on the last index instead of wrapping.
            if (cnt_q == LAST_IDX) state_q <= SCALE;
            else cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        SCALE: begin
          out_q   <= out_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter NUM_INPUTS, default 784: input-vector length (elements per inference).
REQ-002 Parameter NUM_OUTPUTS, default 10: neuron count, all computed in parallel.
REQ-003 Parameter FP_TOTAL_BITS, default 16: signed fixed-point word width of data, weights, bias and outputs.
REQ-004 Parameter FP_FRAC_BITS, default 8: fractional bits of every fixed-point word.
REQ-005 Derived ACC_BITS = 2*FP_TOTAL_BITS + clog2(NUM_INPUTS) + 1: signed accumulator width, never overflows internally.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  begin one inference; honoured only in IDLE.
REQ-009 bias  input  NUM_OUTPUTS x FP_TOTAL_BITS signed  per-neuron bias, sampled on the accepted start edge.
REQ-010 in_valid  input  1  in_data holds a valid element.
REQ-011 in_data  input  FP_TOTAL_BITS signed  current input element.
REQ-012 in_ready  output  1  block accepts an element this cycle.
REQ-013 w_addr  output  clog2(NUM_INPUTS)  index of current element; combinational from element counter.
REQ-014 w_data  input  NUM_OUTPUTS x FP_TOTAL_BITS signed  weights for w_addr, valid in the same cycle (asynchronous ROM).
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse; out_vector valid from this cycle on.
REQ-017 out_vector  output  NUM_OUTPUTS x FP_TOTAL_BITS signed  layer result; feeds the downstream relu stage (done drives its start).

Function
REQ-018 States: IDLE, ACCUM, SCALE; start in IDLE -> ACCUM; start in any other state is ignored.
REQ-019 On accepted start: element counter = 0, acc[j] = sign-extended bias[j] << FP_FRAC_BITS for every j.
REQ-020 in_ready = 1 only in ACCUM; handshake = in_valid & in_ready; in_valid outside ACCUM is ignored.
REQ-021 Per handshake: acc[j] += in_data * w_data[j] (full-precision signed product, sign-extended to ACC_BITS), counter += 1.
REQ-022 No handshake (in_valid low) in ACCUM: accumulators and counter hold; stalls of any length allowed.
REQ-023 Handshake with counter = NUM_INPUTS-1 -> SCALE; counter never wraps.
REQ-024 SCALE, one cycle: r = (acc[j] + 2^(FP_FRAC_BITS-1)) >>> FP_FRAC_BITS (round half up, arithmetic shift).
REQ-025 Saturation: r > 2^(FP_TOTAL_BITS-1)-1 -> max positive; r < -2^(FP_TOTAL_BITS-1) -> most negative; else truncate to FP_TOTAL_BITS.
REQ-026 Edge leaving SCALE: out_vector <= saturated r, done <= 1, state -> IDLE.
REQ-027 Latency: done high in the 2nd cycle after the cycle of the final handshake; minimum start-to-done = NUM_INPUTS+2 cycles.
REQ-028 done high exactly one cycle per inference; start is accepted in the same cycle done is high (state is IDLE).
REQ-029 out_vector holds its value until the next SCALE; unaffected by new start or input traffic.

Reset
REQ-030 reset has priority over all inputs, in any state including mid-ACCUM or SCALE.
REQ-031 On reset: state IDLE, counter 0, all acc 0, out_vector all 0, done 0, busy 0, in_ready 0; a partial inference is discarded with no done.

Verification (NUM_INPUTS=4, NUM_OUTPUTS=2, 16/8 format)
REQ-032 Basic: bias 0, in_data 0x0100 x4, w_data 0x0080 both neurons, no stalls -> out_vector {0x0200,0x0200}, done exactly 6 cycles after start.
REQ-033 Saturation/rounding: in 0x7FFF x4, w {0x7FFF,0x8000} -> {0x7FFF,0x8000}; separately in {0x0001,0,0,0}, w 0x0080 -> 0x0001 (half rounds up).
REQ-034 Stalls: REQ-032 stimulus with in_valid low 3 cycles between every element -> identical result, done 2 cycles after last handshake, in_ready 0 after it.
REQ-035 Bias only: inputs all 0, bias {0xFE80,0x0040} -> {0xFE80,0x0040}; start pulsed again during ACCUM -> ignored, single done.
REQ-036 Reset mid-operation: reset after 2 handshakes -> outputs 0, no done; new start with REQ-032 stimulus -> {0x0200,0x0200}.
